// File: rtl/xbar_pkg.sv
// Shared types for the crossbar literal writer.
// Optional read-back verify is enabled with XBAR_WRITE_VERIFY_EN.
package xbar_pkg;

    typedef enum logic [1:0] {
        KIND_OFF = 2'd0,
        KIND_ON  = 2'd1,
        KIND_POS = 2'd2,
        KIND_NEG = 2'd3
    } kind_e;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_LOAD  = 3'd1;
    localparam state_t ST_ISSUE = 3'd2;
    localparam state_t ST_VREQ  = 3'd3;
    localparam state_t ST_VWAIT = 3'd4;
    localparam state_t ST_DONE  = 3'd5;

    // Index width, never below one bit so degenerate sizes still elaborate.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // One cell entry is {kind[1:0], var[VW-1:0]}.
    function automatic int unsigned cell_w(input int unsigned nvars);
        return 2 + idx_w(nvars);
    endfunction

endpackage

// File: rtl/xbar_lit_eval.sv
// Combinational evaluation of one cell literal.
// Out-of-range variable indices evaluate to OFF.
module xbar_lit_eval
    import xbar_pkg::*;
#(
    parameter int unsigned NVARS = 4
) (
    input  logic [cell_w(NVARS)-1:0] entry_i,
    input  logic [NVARS-1:0]         vars_i,
    output logic                     lit_o
);

    localparam int unsigned VW = idx_w(NVARS);
    localparam int unsigned EW = cell_w(NVARS);

    kind_e         kind;
    logic [VW-1:0] vsel;
    logic          hit;
    logic          bit_v;

    // Select the referenced variable and apply the literal kind.
    always_comb begin
        kind  = kind_e'(entry_i[EW-1 -: 2]);
        vsel  = entry_i[VW-1:0];
        hit   = 1'b0;
        bit_v = 1'b0;
        lit_o = 1'b0;
        for (int i = 0; i < int'(NVARS); i++) begin
            if (vsel == VW'(i)) begin
                hit   = 1'b1;
                bit_v = vars_i[i];
            end
        end
        unique case (kind)
            KIND_OFF: lit_o = 1'b0;
            KIND_ON:  lit_o = 1'b1;
            KIND_POS: lit_o = hit & bit_v;
            KIND_NEG: lit_o = hit & ~bit_v;
            default:  lit_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/xbar_writer.sv
// Programs every crossbar cell in row-major order from a literal map.
// XBAR_WRITE_VERIFY_EN adds read-back verify with bounded rewrites.
module xbar_writer
    import xbar_pkg::*;
#(
    parameter int unsigned ROWS      = 3,
    parameter int unsigned COLS      = 4,
    parameter int unsigned NVARS     = 4,
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                start_i,
    input  logic [NVARS-1:0]                    vars_i,
    input  logic [ROWS*COLS*cell_w(NVARS)-1:0]  cfg_i,
    output logic                                busy_o,
    output logic                                done_o,
    output logic                                cmd_valid_o,
    input  logic                                cmd_ready_i,
    output logic [idx_w(ROWS)-1:0]              cmd_row_o,
    output logic [idx_w(COLS)-1:0]              cmd_col_o,
    output logic                                cmd_rd_o,
    output logic                                cmd_data_o,
    input  logic                                rd_valid_i,
    input  logic                                rd_data_i,
    output logic                                err_o
);

    localparam int unsigned EW = cell_w(NVARS);
    localparam int unsigned RW = idx_w(ROWS);
    localparam int unsigned CW = idx_w(COLS);
    localparam int unsigned NB = ROWS * COLS * EW;

    state_t         state_q, state_d;
    logic [RW-1:0]  row_q, row_d;
    logic [CW-1:0]  col_q, col_d;
    logic [NVARS-1:0] vars_q, vars_d;
    logic [NB-1:0]  cfg_q, cfg_d;
    logic [EW-1:0]  entry;
    logic           lit;
    logic           adv;
    logic           last_col;
    logic           last_row;

`ifdef XBAR_WRITE_VERIFY_EN
    localparam int unsigned TW = idx_w(MAX_RETRY + 1);
    logic [TW-1:0]  retry_q, retry_d;
    logic           err_q, err_d;
`else
    logic           unused_rd;
    assign unused_rd = ^{rd_valid_i, rd_data_i, (MAX_RETRY > 0)};
`endif

    // Pick the latched map entry of the cell currently addressed.
    always_comb begin
        entry = '0;
        for (int r = 0; r < int'(ROWS); r++) begin
            for (int c = 0; c < int'(COLS); c++) begin
                if (row_q == RW'(r) && col_q == CW'(c)) begin
                    entry = cfg_q[(r*COLS+c)*EW +: EW];
                end
            end
        end
    end

    xbar_lit_eval #(
        .NVARS(NVARS)
    ) u_lit (
        .entry_i (entry),
        .vars_i  (vars_q),
        .lit_o   (lit)
    );

    assign last_col = (col_q == CW'(COLS - 1));
    assign last_row = (row_q == RW'(ROWS - 1));

    // Sequencer: latch, issue each cell, optionally verify, then finish.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        vars_d  = vars_q;
        cfg_d   = cfg_q;
        adv     = 1'b0;
`ifdef XBAR_WRITE_VERIFY_EN
        retry_d = retry_q;
        err_d   = err_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_LOAD;
                    vars_d  = vars_i;
                    cfg_d   = cfg_i;
`ifdef XBAR_WRITE_VERIFY_EN
                    err_d   = 1'b0;
                    retry_d = '0;
`endif
                end
            end
            ST_LOAD: begin
                row_d   = '0;
                col_d   = '0;
                state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (cmd_ready_i) begin
`ifdef XBAR_WRITE_VERIFY_EN
                    state_d = ST_VREQ;
`else
                    adv = 1'b1;
`endif
                end
            end
`ifdef XBAR_WRITE_VERIFY_EN
            ST_VREQ: begin
                if (cmd_ready_i) state_d = ST_VWAIT;
            end
            ST_VWAIT: begin
                if (rd_valid_i) begin
                    if (rd_data_i == lit) begin
                        adv = 1'b1;
                    end else if (retry_q < TW'(MAX_RETRY)) begin
                        retry_d = retry_q + 1'b1;
                        state_d = ST_ISSUE;
                    end else begin
                        err_d = 1'b1;
                        adv   = 1'b1;
                    end
                end
            end
`endif
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (adv) begin
`ifdef XBAR_WRITE_VERIFY_EN
            retry_d = '0;
`endif
            if (last_col) begin
                col_d = '0;
                if (last_row) begin
                    row_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    row_d   = row_q + 1'b1;
                    state_d = ST_ISSUE;
                end
            end else begin
                col_d   = col_q + 1'b1;
                state_d = ST_ISSUE;
            end
        end
    end

    // Core state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            vars_q  <= '0;
            cfg_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            vars_q  <= vars_d;
            cfg_q   <= cfg_d;
        end
    end

`ifdef XBAR_WRITE_VERIFY_EN
    // Retry counter and sticky verify error.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            retry_q <= '0;
            err_q   <= 1'b0;
        end else begin
            retry_q <= retry_d;
            err_q   <= err_d;
        end
    end
    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    assign cmd_valid_o = (state_q == ST_ISSUE) || (state_q == ST_VREQ);
    assign cmd_rd_o    = (state_q == ST_VREQ);
    assign cmd_row_o   = row_q;
    assign cmd_col_o   = col_q;
    assign cmd_data_o  = cmd_valid_o & lit;
    assign done_o      = (state_q == ST_DONE);
    assign busy_o      = (state_q == ST_LOAD) || (state_q == ST_ISSUE) ||
                         (state_q == ST_VREQ) || (state_q == ST_VWAIT);

endmodule

// File: tb/tb_xbar_writer.sv
// Directed bench for xbar_writer (default 3x4 array, 4 variables).
// Verify-mode sequence compiles in with XBAR_WRITE_VERIFY_EN.
module tb_xbar_writer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic [3:0]  vars_i = '0;
    logic [47:0] cfg_i = '0;
    logic        busy_o, done_o, cmd_valid_o;
    logic        cmd_ready_i = 1'b0;
    logic [1:0]  cmd_row_o, cmd_col_o;
    logic        cmd_rd_o, cmd_data_o;
    logic        rd_valid_i = 1'b0;
    logic        rd_data_i = 1'b0;
    logic        err_o;

    xbar_writer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .vars_i      (vars_i),
        .cfg_i       (cfg_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .cmd_valid_o (cmd_valid_o),
        .cmd_ready_i (cmd_ready_i),
        .cmd_row_o   (cmd_row_o),
        .cmd_col_o   (cmd_col_o),
        .cmd_rd_o    (cmd_rd_o),
        .cmd_data_o  (cmd_data_o),
        .rd_valid_i  (rd_valid_i),
        .rd_data_i   (rd_data_i),
        .err_o       (err_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] r;
        logic [1:0] c;
        logic       d;
    } wr_t;

    typedef struct {
        logic [47:0] cfg;
        logic [3:0]  vars;
        logic [11:0] exp;
    } vec_t;

    localparam logic [47:0] ALL_ON = 48'h444444444444;

    wr_t wlog[$];
    int  done_cnt = 0;
    int  rd_cnt = 0;
    longint last_wr_t = 0;
    longint done_t = 0;
    int  total = 0;
    int  bad = 0;
    bit  flip_en = 1'b0;

    // Accepted commands and done pulses, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (cmd_valid_o && cmd_ready_i) begin
                if (!cmd_rd_o) begin
                    wlog.push_back('{r: cmd_row_o, c: cmd_col_o, d: cmd_data_o});
                    last_wr_t = $time;
                end else begin
                    rd_cnt++;
                end
            end
            if (done_o) begin
                done_cnt++;
                done_t = $time;
            end
        end
    end

`ifdef XBAR_WRITE_VERIFY_EN
    bit   rd_pend = 1'b0;
    logic rd_val  = 1'b0;
    // Array model: answer each accepted read one cycle later.
    always @(negedge clk) begin
        rd_valid_i = 1'b0;
        if (rd_pend) begin
            rd_valid_i = 1'b1;
            rd_data_i  = rd_val;
            rd_pend    = 1'b0;
        end
        if (rst_n && cmd_valid_o && cmd_ready_i && cmd_rd_o) begin
            rd_pend = 1'b1;
            rd_val  = cmd_data_o ^ (flip_en && cmd_row_o == 2'd2 &&
                                    cmd_col_o == 2'd1);
        end
    end
`endif

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_log();
        wlog.delete();
        done_cnt = 0;
        rd_cnt = 0;
    endtask

    // Start one programming pass and serve it until done or abort.
    task automatic run(input logic [47:0] cfg, input logic [3:0] vars,
                       input int stall_len, input int abort_after,
                       input int restart_at);
        int cyc = 0;
        int stalled = 0;
        bit ok = 1'b0;
        clear_log();
        @(posedge clk); #1;
        cfg_i = cfg;
        vars_i = vars;
        start_i = 1'b1;
        cmd_ready_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        cfg_i = ~cfg;
        vars_i = ~vars;
        while (cyc < 300) begin
            if (done_cnt > 0) begin ok = 1'b1; break; end
            if (abort_after > 0 && wlog.size() == abort_after) begin
                ok = 1'b1;
                break;
            end
            start_i = (restart_at > 0 && wlog.size() == restart_at);
            if (stall_len > 0 && cmd_valid_o && !cmd_rd_o &&
                cmd_row_o == 2'd0 && cmd_col_o == 2'd3 &&
                stalled < stall_len) begin
                cmd_ready_i = 1'b0;
                stalled++;
                chk("stall_data", cmd_data_o, 1'b1);
                chk("stall_rd", cmd_rd_o, 1'b0);
            end else begin
                cmd_ready_i = 1'b1;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start_i = 1'b0;
        chk("timeout", ok, 1'b1);
        if (stall_len > 0) chk("stall_cycles", stalled, stall_len);
        if (abort_after == 0) begin
            repeat (4) begin @(posedge clk); #1; end
            chk("idle_busy", busy_o, 1'b0);
        end
    endtask

    task automatic check_run(input string tag, input logic [11:0] exp_d);
        logic [11:0] got = '0;
        bit ord = (wlog.size() == 12);
        chk({tag, "_nwr"}, wlog.size(), 12);
        for (int i = 0; i < 12 && i < wlog.size(); i++) begin
            got[i] = wlog[i].d;
            if (wlog[i].r != 2'(i / 4) || wlog[i].c != 2'(i % 4)) ord = 1'b0;
        end
        chk({tag, "_order"}, ord, 1'b1);
        chk({tag, "_data"}, got, exp_d);
        chk({tag, "_ndone"}, done_cnt, 1);
`ifndef XBAR_WRITE_VERIFY_EN
        chk({tag, "_done_lat"}, done_t - last_wr_t, 10);
`endif
    endtask

    vec_t vt[6];

    initial begin
        int cyc;
        vt[0] = '{cfg: ALL_ON,            vars: 4'b0000, exp: 12'hFFF};
        vt[1] = '{cfg: 48'h000000000000, vars: 4'b1111, exp: 12'h000};
        vt[2] = '{cfg: 48'h44444E444444, vars: 4'b0100, exp: 12'hFBF};
        vt[3] = '{cfg: 48'h44444A444444, vars: 4'b0100, exp: 12'hFFF};
        vt[4] = '{cfg: 48'hBA98BA98BA98, vars: 4'b1010, exp: 12'hAAA};
        vt[5] = '{cfg: 48'hFEDCFEDCFEDC, vars: 4'b1010, exp: 12'h555};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_done", done_o, 1'b0);
        chk("rst_valid", cmd_valid_o, 1'b0);
        chk("rst_row", cmd_row_o, 2'd0);
        chk("rst_col", cmd_col_o, 2'd0);
        chk("rst_rd", cmd_rd_o, 1'b0);
        chk("rst_data", cmd_data_o, 1'b0);
        chk("rst_err", err_o, 1'b0);
        rst_n = 1'b1;

        // First command two cycles after start; ready high early is harmless.
        clear_log();
        @(posedge clk); #1;
        cfg_i = ALL_ON;
        vars_i = 4'b0000;
        start_i = 1'b1;
        cmd_ready_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        chk("lat_busy", busy_o, 1'b1);
        chk("lat_valid_load", cmd_valid_o, 1'b0);
        @(posedge clk); #1;
        chk("lat_valid", cmd_valid_o, 1'b1);
        chk("lat_row", cmd_row_o, 2'd0);
        chk("lat_col", cmd_col_o, 2'd0);
        chk("lat_data", cmd_data_o, 1'b1);
        cyc = 0;
        while (done_cnt == 0 && cyc < 300) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("lat_timeout", done_cnt > 0, 1'b1);
        repeat (3) begin @(posedge clk); #1; end
        check_run("lat", 12'hFFF);

        for (int v = 0; v < 6; v++) begin
            run(vt[v].cfg, vt[v].vars, 0, 0, 0);
            check_run($sformatf("vec%0d", v), vt[v].exp);
        end

        run(ALL_ON, 4'b0000, 5, 0, 0);
        check_run("stall", 12'hFFF);

        run(ALL_ON, 4'b0000, 0, 6, 0);
        rst_n = 1'b0;
        cmd_ready_i = 1'b0;
        @(posedge clk); #1;
        chk("abort_valid", cmd_valid_o, 1'b0);
        chk("abort_busy", busy_o, 1'b0);
        chk("abort_done", done_o, 1'b0);
        chk("abort_row", cmd_row_o, 2'd0);
        chk("abort_col", cmd_col_o, 2'd0);
        rst_n = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        chk("abort_nwr", wlog.size(), 6);
        chk("abort_ndone", done_cnt, 0);
        run(vt[4].cfg, vt[4].vars, 0, 0, 0);
        check_run("restart", 12'hAAA);

        run(vt[5].cfg, vt[5].vars, 0, 0, 4);
        check_run("busy_start", 12'h555);

`ifdef XBAR_WRITE_VERIFY_EN
        chk("vfy_nrd_prev", rd_cnt, 12);
        flip_en = 1'b1;
        run(ALL_ON, 4'b0000, 0, 0, 0);
        flip_en = 1'b0;
        chk("vfy_nwr", wlog.size(), 15);
        chk("vfy_err", err_o, 1'b1);
        chk("vfy_ndone", done_cnt, 1);
        if (wlog.size() == 15) begin
            chk("vfy_rw_cell", {wlog[9], wlog[12]}, {5'b10011, 5'b10011});
            chk("vfy_last", wlog[14], 5'b10111);
        end
        run(ALL_ON, 4'b0000, 0, 0, 0);
        chk("vfy_err_clr", err_o, 1'b0);
`else
        chk("err_tied", err_o, 1'b0);
        chk("no_reads", rd_cnt, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
